// File: rtl/fetch_sequencer.sv
// Fetch-side sequencer for a variable-latency instruction memory: drives the
// ROM request handshake and the StallF/StallD/FlushD controls of the fetch stage.
module fetch_sequencer #(
  parameter int D_WIDTH   = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [D_WIDTH-1:0]   PCF,
  input  logic                 PCSrcE,
  input  logic                 HazStallD,
  output logic                 imem_req,
  output logic [D_WIDTH-1:0]   imem_addr,
  input  logic                 imem_ack,
  input  logic [D_WIDTH-1:0]   imem_rdata,
  output logic [D_WIDTH-1:0]   InstrF,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 FlushD,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [D_WIDTH-1:0]   instr_q;
  logic [D_WIDTH-1:0]   addr_q;
  logic [D_WIDTH-1:0]   last_q;
  logic [D_WIDTH-1:0]   last_nxt;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 load_instr;
  logic                 load_addr;
  logic                 load_last;
  logic                 bump_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      instr_q <= '0;
      addr_q  <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state <= state_nxt;
      if (load_instr) instr_q <= imem_rdata;
      if (load_addr)  addr_q  <= PCF;
      if (load_last)  last_q  <= last_nxt;
      if (bump_cnt)   cnt_q   <= cnt_q + CNT_WIDTH'(1);
    end
  end

  // imem_req depends only on the registered state, so no input reaches it combinationally.
  always_comb begin
    state_nxt  = state;
    imem_req   = 1'b0;
    imem_addr  = PCF;
    InstrF     = last_q;
    StallF     = 1'b1;
    StallD     = 1'b0;
    FlushD     = 1'b1;
    load_instr = 1'b0;
    load_addr  = 1'b0;
    load_last  = 1'b0;
    last_nxt   = imem_rdata;
    bump_cnt   = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = REQ;
      end
      REQ: begin
        imem_req  = 1'b1;
        imem_addr = PCF;
        if (PCSrcE) begin
          StallF   = 1'b0;
          bump_cnt = 1'b1;
          if (imem_ack) begin
            state_nxt = REQ;
          end else begin
            load_addr = 1'b1;
            state_nxt = DROP;
          end
        end else if (imem_ack && !HazStallD) begin
          InstrF    = imem_rdata;
          StallF    = 1'b0;
          FlushD    = 1'b0;
          load_last = 1'b1;
        end else if (imem_ack) begin
          InstrF     = imem_rdata;
          StallD     = 1'b1;
          FlushD     = 1'b0;
          load_instr = 1'b1;
          load_last  = 1'b1;
          state_nxt  = HOLD;
        end else if (HazStallD) begin
          StallD   = 1'b1;
          FlushD   = 1'b0;
          bump_cnt = 1'b1;
        end else begin
          bump_cnt = 1'b1;
        end
      end
      HOLD: begin
        InstrF    = instr_q;
        load_last = 1'b1;
        last_nxt  = instr_q;
        if (PCSrcE) begin
          StallF    = 1'b0;
          state_nxt = REQ;
        end else if (HazStallD) begin
          StallD = 1'b1;
          FlushD = 1'b0;
        end else begin
          StallF    = 1'b0;
          FlushD    = 1'b0;
          state_nxt = REQ;
        end
      end
      DROP: begin
        // Keep the abandoned request stable until its stale response returns.
        imem_req  = 1'b1;
        imem_addr = addr_q;
        bump_cnt  = 1'b1;
        if (imem_ack) state_nxt = REQ;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer: a flag-based model of the sequencing rules,
// a variable-latency memory and a PC register drive the DUT and predict its outputs.
module tb_fetch_sequencer;
  localparam int DW = 32;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] PCF;
  logic          PCSrcE;
  logic          HazStallD;
  logic          imem_req;
  logic [DW-1:0] imem_addr;
  logic          imem_ack;
  logic [DW-1:0] imem_rdata;
  logic [DW-1:0] InstrF;
  logic          StallF;
  logic          StallD;
  logic          FlushD;
  logic [CW-1:0] stall_cnt;

  int vectors     = 0;
  int miscompares = 0;

  logic          m_idle, m_hold, m_drop;
  logic [DW-1:0] m_drop_addr, m_held, m_last, m_pc;
  logic [CW-1:0] m_cnt;
  logic          mem_busy;
  int            mem_cnt, mem_lat;

  always #5 clk = ~clk;

  fetch_sequencer #(.D_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .PCF(PCF), .PCSrcE(PCSrcE), .HazStallD(HazStallD),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .InstrF(InstrF), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .stall_cnt(stall_cnt)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, predict and check, commit at the rising edge.
  task automatic applyStimulus(input int lat_min, input int lat_max, input int haz_pct,
                               input int pc_pct, input int rst_pct, input int stale_pct);
    logic          e_req, e_sf, e_sd, e_fd, bump, chk_instr;
    logic [DW-1:0] e_addr, e_instr;
    logic          n_idle, n_hold, n_drop;
    logic [DW-1:0] n_drop_addr, n_held, n_last, n_pc;
    logic [CW-1:0] n_cnt;
    @(negedge clk);
    PCF       = m_pc;
    rst       = (int'($urandom_range(99)) < rst_pct);
    PCSrcE    = (int'($urandom_range(99)) < pc_pct);
    HazStallD = (int'($urandom_range(99)) < haz_pct);
    e_req  = !m_idle && !m_hold;
    e_addr = m_drop ? m_drop_addr : m_pc;
    if (e_req) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_cnt  = 0;
        mem_lat  = int'($urandom_range(lat_max, lat_min));
      end
      imem_ack   = (mem_cnt == mem_lat);
      imem_rdata = e_addr + 32'h100;
    end else begin
      imem_ack   = (int'($urandom_range(99)) < stale_pct);
      imem_rdata = $urandom;
    end
    #1;
    e_sf = 1'b1; e_sd = 1'b0; e_fd = 1'b1; e_instr = m_last; chk_instr = 1'b0; bump = 1'b0;
    n_idle = m_idle; n_hold = m_hold; n_drop = m_drop; n_drop_addr = m_drop_addr;
    n_held = m_held; n_last = m_last; n_pc = m_pc;
    if (m_idle) begin
      n_idle = 1'b0;
    end else if (m_hold) begin
      e_instr = m_held; chk_instr = 1'b1;
      if (PCSrcE) begin
        e_sf = 1'b0; n_hold = 1'b0;
      end else if (HazStallD) begin
        e_sd = 1'b1; e_fd = 1'b0;
      end else begin
        e_sf = 1'b0; e_fd = 1'b0; n_hold = 1'b0;
      end
    end else if (m_drop) begin
      bump = 1'b1;
      if (imem_ack) n_drop = 1'b0;
    end else begin
      if (PCSrcE) begin
        e_sf = 1'b0; bump = 1'b1;
        if (!imem_ack) begin
          n_drop = 1'b1; n_drop_addr = m_pc;
        end
      end else if (imem_ack) begin
        e_fd = 1'b0; n_last = imem_rdata;
        if (HazStallD) begin
          e_sd = 1'b1; n_hold = 1'b1; n_held = imem_rdata;
        end else begin
          e_sf = 1'b0; e_instr = imem_rdata; chk_instr = 1'b1;
        end
      end else begin
        bump = 1'b1;
        if (HazStallD) begin
          e_sd = 1'b1; e_fd = 1'b0;
        end
      end
    end
    checkOutput("imem_req", imem_req, e_req);
    checkOutput("StallF", StallF, e_sf);
    checkOutput("StallD", StallD, e_sd);
    checkOutput("FlushD", FlushD, e_fd);
    checkOutput("stall_cnt", stall_cnt, m_cnt);
    if (e_req) checkOutput("imem_addr", imem_addr, e_addr);
    if (chk_instr) checkOutput("InstrF", InstrF, e_instr);
    if (!e_sf) n_pc = PCSrcE ? ($urandom & 32'hFFFF_FFFC) : m_pc + 32'd4;
    n_cnt = m_cnt + (bump ? 32'd1 : 32'd0);
    if (e_req && mem_busy) begin
      if (imem_ack) mem_busy = 1'b0;
      else mem_cnt++;
    end
    if (rst) begin
      n_idle = 1'b1; n_hold = 1'b0; n_drop = 1'b0; n_cnt = '0;
      n_held = '0; n_drop_addr = '0; n_last = '0; mem_busy = 1'b0;
    end
    @(posedge clk);
    m_idle = n_idle; m_hold = n_hold; m_drop = n_drop; m_drop_addr = n_drop_addr;
    m_held = n_held; m_last = n_last; m_pc = n_pc; m_cnt = n_cnt;
  endtask

  initial begin
    rst = 1'b1; PCSrcE = 1'b0; HazStallD = 1'b0; imem_ack = 1'b0;
    imem_rdata = '0; PCF = '0;
    repeat (2) @(posedge clk);
    m_idle = 1'b1; m_hold = 1'b0; m_drop = 1'b0; m_drop_addr = '0;
    m_held = '0; m_last = '0; m_pc = '0; m_cnt = '0;
    mem_busy = 1'b0; mem_cnt = 0; mem_lat = 0;
    @(negedge clk);
    #1;
    checkOutput("reset_InstrF", InstrF, 32'd0);
    checkOutput("reset_stall_cnt", stall_cnt, 32'd0);
    checkOutput("reset_imem_req", imem_req, 1'b0);

    applyStimulus(0, 0, 0, 0, 100, 0);
    repeat (40) applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 100, 0);
    repeat (40) applyStimulus(2, 2, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 100, 0);
    repeat (300) applyStimulus(0, 1, 40, 0, 0, 30);
    repeat (300) applyStimulus(2, 2, 20, 15, 0, 30);
    repeat (4000) applyStimulus(0, 3, 25, 12, 2, 30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
